// File: rtl/uart_resp_rx.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO, with OK\r\n / ERROR\r\n token detection.
// Byte, flags and pulses appear the cycle after the stop-bit sample; bytes arriving while full are dropped and flagged sticky.
module uart_resp_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_rd,
    output logic [7:0] o_data_out,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow,
    output logic       o_frame_err,
    output logic       o_ok_seen,
    output logic       o_err_seen
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    function automatic logic [7:0] ok_char(input logic [2:0] i);
        case (i)
            3'd0:    ok_char = 8'h4F;
            3'd1:    ok_char = 8'h4B;
            3'd2:    ok_char = 8'h0D;
            3'd3:    ok_char = 8'h0A;
            default: ok_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] er_char(input logic [2:0] i);
        case (i)
            3'd0:    er_char = 8'h45;
            3'd1:    er_char = 8'h52;
            3'd2:    er_char = 8'h52;
            3'd3:    er_char = 8'h4F;
            3'd4:    er_char = 8'h52;
            3'd5:    er_char = 8'h0D;
            3'd6:    er_char = 8'h0A;
            default: er_char = 8'h00;
        endcase
    endfunction

    logic            r_sync1;
    logic            r_rxs;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            w_byte_vld;
    logic            w_ferr;

    logic [7:0]      r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            r_overflow;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    logic [2:0]      r_pok;
    logic [2:0]      r_per;
    logic            w_ok_hit;
    logic            w_er_hit;
    logic            r_ok_seen;
    logic            r_err_seen;
    logic            r_frame_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_vld  = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_cnt_nxt   = CNT_HALF;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = CNT_BIT;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    // Shift right so the first (LSB) bit lands in bit 0 after eight samples.
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    w_cnt_nxt   = CNT_BIT;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (r_rxs) begin
                    w_byte_vld  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_rd && !w_empty;
    // A pop on the same edge frees the slot the incoming byte needs.
    assign w_push  = w_byte_vld && (!w_full || w_pop);
    assign w_drop  = w_byte_vld && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= r_shift;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_ok_hit = (r_shift == ok_char(r_pok));
    assign w_er_hit = (r_shift == er_char(r_per));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pok       <= '0;
            r_per       <= '0;
            r_ok_seen   <= 1'b0;
            r_err_seen  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_ok_seen   <= w_byte_vld && w_ok_hit && (r_pok == 3'd3);
            r_err_seen  <= w_byte_vld && w_er_hit && (r_per == 3'd6);
            r_frame_err <= w_ferr;
            if (w_byte_vld) begin
                if (w_ok_hit) begin
                    r_pok <= (r_pok == 3'd3) ? 3'd0 : r_pok + 3'd1;
                end else begin
                    r_pok <= (r_shift == 8'h4F) ? 3'd1 : 3'd0;
                end
                if (w_er_hit) begin
                    r_per <= (r_per == 3'd6) ? 3'd0 : r_per + 3'd1;
                end else begin
                    r_per <= (r_shift == 8'h45) ? 3'd1 : 3'd0;
                end
            end
        end
    end

    assign o_data_out  = r_mem[r_rptr[AW-1:0]];
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_frame_err = r_frame_err;
    assign o_ok_seen   = r_ok_seen;
    assign o_err_seen  = r_err_seen;
endmodule

// File: tb/tb_uart_resp_rx.sv
// Bench for uart_resp_rx: directed frames, queue-based reference model compared every cycle.
module tb_uart_resp_rx;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    localparam int LAT   = 98;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] data_out;
    logic       empty, full, overflow, frame_err, ok_seen, err_seen;

    uart_resp_rx #(
        .CLK_FREQ(1000000),
        .BAUD    (100000),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .i_rd       (rd),
        .o_data_out (data_out),
        .o_empty    (empty),
        .o_full     (full),
        .o_overflow (overflow),
        .o_frame_err(frame_err),
        .o_ok_seen  (ok_seen),
        .o_err_seen (err_seen)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int fe_cnt = 0;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         fe;
    } ev_t;
    ev_t        evq[$];
    logic [7:0] mq[$];
    logic [7:0] hist[7];
    bit         m_ovf, m_ok, m_err, m_fe;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_y(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: byte arrivals are scheduled by the sender at the stop-sample edge.
    always @(posedge clk) begin : model
        bit pop;
        cyc++;
        m_ok  = 1'b0;
        m_err = 1'b0;
        m_fe  = 1'b0;
        if (!rst) begin
            mq.delete();
            evq.delete();
            m_ovf = 1'b0;
            foreach (hist[i]) hist[i] = 8'h00;
        end else begin
            pop = rd && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].fe) begin
                    m_fe = 1'b1;
                end else begin
                    if (mq.size() < DEPTH) mq.push_back(evq[0].b);
                    else m_ovf = 1'b1;
                    for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = evq[0].b;
                    m_ok  = ({hist[3], hist[2], hist[1], hist[0]} == 32'h4F4B0D0A);
                    m_err = ({hist[6], hist[5], hist[4], hist[3], hist[2], hist[1], hist[0]}
                             == 56'h4552524F520D0A);
                end
                void'(evq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk_b("empty", empty, mq.size() == 0);
            chk_b("full", full, mq.size() == DEPTH);
            chk_b("overflow", overflow, m_ovf);
            chk_b("frame_err", frame_err, m_fe);
            chk_b("ok_seen", ok_seen, m_ok);
            chk_b("err_seen", err_seen, m_err);
            if (mq.size() > 0) chk_y("data_out", data_out, mq[0]);
        end
        if (ok_seen === 1'b1) ok_cnt++;
        if (err_seen === 1'b1) err_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    // Called and returning at a falling edge; stop_lo>0 holds the stop bit low that many clocks.
    task automatic send(input logic [7:0] b, input int stop_lo, input bit rd_stop, input bit chk_lat);
        ev_t e;
        rx   = 1'b0;
        e.at = cyc + LAT;
        e.b  = b;
        e.fe = (stop_lo != 0);
        evq.push_back(e);
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        if (stop_lo > 0) begin
            rx = 1'b0;
            repeat (stop_lo) @(negedge clk);
            rx = 1'b1;
            repeat (DIV) @(negedge clk);
        end else begin
            rx = 1'b1;
            for (int j = 0; j < DIV; j++) begin
                if (chk_lat && j == 7) chk_b("lat_empty_97", empty, 1'b1);
                if (chk_lat && j == 8) chk_b("lat_empty_98", empty, 1'b0);
                rd = rd_stop && (j == 7);
                @(negedge clk);
            end
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int o0, e0, f0;
        string er;
        er = "ERRO";
        repeat (3) @(negedge clk);
        chk_b("rst_empty", empty, 1'b1);
        chk_b("rst_full", full, 1'b0);
        chk_b("rst_overflow", overflow, 1'b0);
        chk_y("rst_data_out", data_out, 8'h00);
        chk_b("rst_pulses", ok_seen | err_seen | frame_err, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 0, 1'b0, 1'b1);
        chk_y("a5_data", data_out, 8'hA5);
        pop_one();
        chk_b("a5_popped", empty, 1'b1);

        o0 = ok_cnt; e0 = err_cnt;
        send_str("OK\r\n");
        chk_i("ok_pulse", ok_cnt - o0, 1);
        chk_i("ok_no_err", err_cnt - e0, 0);
        repeat (4) pop_one();

        o0 = ok_cnt;
        send_str("OOK\r\n");
        chk_i("ook_pulse", ok_cnt - o0, 1);
        chk_b("ook_overflow", overflow, 1'b1);
        do_reset();
        chk_b("reset_ovf_clear", overflow, 1'b0);

        o0 = ok_cnt; e0 = err_cnt;
        send_str("ERROR\r\n");
        chk_i("err_pulse", err_cnt - e0, 1);
        chk_i("err_no_ok", ok_cnt - o0, 0);
        chk_b("err_overflow", overflow, 1'b1);
        chk_b("err_full", full, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_y("err_fifo", data_out, er[i]);
            pop_one();
        end
        chk_b("err_drained", empty, 1'b1);

        f0 = fe_cnt;
        send(8'h3C, 3 * DIV, 1'b0, 1'b0);
        chk_i("ferr_pulse", fe_cnt - f0, 1);
        chk_b("ferr_no_byte", empty, 1'b1);
        send(8'h55, 0, 1'b0, 1'b0);
        chk_y("after_ferr_data", data_out, 8'h55);
        pop_one();

        f0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk_i("glitch_no_ferr", fe_cnt - f0, 0);
        chk_b("glitch_no_byte", empty, 1'b1);
        send(8'h11, 0, 1'b0, 1'b0);
        chk_y("after_glitch_data", data_out, 8'h11);

        do_reset();
        send(8'h11, 0, 1'b0, 1'b0);
        send(8'h22, 0, 1'b0, 1'b0);
        send(8'h33, 0, 1'b0, 1'b0);
        send(8'h44, 0, 1'b0, 1'b0);
        chk_b("fill_full", full, 1'b1);
        send(8'h66, 0, 1'b1, 1'b0);
        chk_b("rdwr_full", full, 1'b1);
        chk_b("rdwr_no_ovf", overflow, 1'b0);
        chk_y("rdwr_head", data_out, 8'h22);
        send(8'h77, 0, 1'b0, 1'b0);
        chk_b("drop_ovf", overflow, 1'b1);

        rx = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_b("mid_rst_empty", empty, 1'b1);
        chk_b("mid_rst_full", full, 1'b0);
        chk_b("mid_rst_ovf", overflow, 1'b0);
        chk_y("mid_rst_data", data_out, 8'h00);
        repeat (120) @(negedge clk);
        chk_b("mid_rst_quiet", empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_resp_rx.md
# uart_resp_rx

- Receive-side companion of the command transmitter in the Comunicaciones path: deserializes the module's `rx` line (8N1, LSB first) into bytes.
- Buffers received bytes in a small first-word-fall-through FIFO for the J1 SoC to read.
- Scans the byte stream for the response tokens `OK\r\n` and `ERROR\r\n`, so the command sequencer can tell when a command such as `command` 0..4 has been acknowledged.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- DIV = CLK_FREQ/BAUD (floor, localparam), clocks per bit; must be ≥ 4.
- DEPTH, 16, FIFO entries; power of two.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- rd  in  1  pop request; ignored while empty.
- data_out  out  8  FIFO head; valid while empty=0; 8'h00 after reset.
- empty  out  1  FIFO empty; reset 1.
- full  out  1  FIFO holds DEPTH bytes; reset 0.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full; reset 0; cleared only by rst.
- frame_err  out  1  one-cycle pulse on a bad stop bit; reset 0.
- ok_seen  out  1  one-cycle pulse when `OK\r\n` completes; reset 0.
- err_seen  out  1  one-cycle pulse when `ERROR\r\n` completes; reset 0.

## Operation
Input synchronizer:
- rx passes through two flops, both reset to 1; `rxs` is the second-stage output.

Receiver FSM (states IDLE, START, DATA, STOP, WAIT_HIGH) with bit-period counter `cnt` and bit index `idx` (0..7):
- IDLE: on rxs=0, load cnt=DIV/2-1 and go to START.
- START: count cnt down to 0, then sample rxs.
  - rxs=1 → glitch; return to IDLE with no output.
  - rxs=0 → load cnt=DIV-1, idx=0, go to DATA.
- DATA: at each cnt=0, shift rxs into bit idx (LSB first) and reload DIV-1. After idx=7, go to STOP.
- STOP: at cnt=0, sample rxs.
  - 1 → byte valid for one cycle; return to IDLE.
  - 0 → pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break condition from re-triggering reception.

FIFO:
- Circular buffer, DEPTH entries, read/write pointers one bit wider than the address.
- A valid byte is written when not full. If full and no pop occurs in the same cycle, the byte is dropped and overflow is set.
- Simultaneous write and pop while full: both happen; full stays 1.
- Simultaneous write and pop while empty: the write happens; the pop is ignored.
- rd with empty=1 has no effect.
- Pointers wrap modulo DEPTH.

Token matcher (runs on every valid byte, including bytes dropped by a full FIFO):
- Independent progress counters: pOK for `O`,`K`,8'h0D,8'h0A and pER for `E`,`R`,`R`,`O`,`R`,8'h0D,8'h0A.
- Byte equals the expected character → counter increments.
- Byte does not match → counter becomes 1 if the byte equals the first character of that token, else 0.
- Reaching full length pulses ok_seen or err_seen and clears that counter.
- Matching is case-sensitive.
- Framing-error bytes do not affect the counters.

Reset:
- rst=0 at any clock edge, including mid-frame, returns the FSM to IDLE, clears FIFO pointers, counters and all flags, and drives outputs to their reset values on the next edge.

## Timing
- Reference edge T0 is the first edge at which rxs=0 in IDLE, i.e. 2 clocks after rx falls.
- Sample points:
  - Start bit at T0+DIV/2.
  - Data bit k (k=0..7) at T0+DIV/2+(k+1)·DIV.
  - Stop bit at T0+DIV/2+9·DIV.
- The FIFO write and the matcher update occur on the stop-sample edge.
- empty falls, data_out presents the byte, and ok_seen/err_seen/frame_err pulse all in the cycle immediately after the stop-sample edge.
- Pop: rd=1 at edge E advances the head. data_out, empty and full reflect the new state after E.
- Back-to-back frames: the FSM returns to IDLE immediately after STOP, so a start bit arriving during the second half of the stop bit is caught.
- Continuous throughput of one byte per 10·DIV clocks needs no stalls.

## Test plan
Use CLK_FREQ=1000000, BAUD=100000 (DIV=10), DEPTH=4.
- Reset then one frame carrying 8'hA5 → empty=0 exactly 2+5+90+1 clocks after the rx fall; data_out=8'hA5; rd pop → empty=1.
- Send `O`,`K`,8'h0D,8'h0A → ok_seen pulses once for one cycle after the fourth byte; err_seen stays 0. Send `OOK\r\n` → ok_seen pulses once (restart rule).
- Send `ERROR\r\n` → err_seen pulses once after 8'h0A; ok_seen stays 0. FIFO holds the first 4 bytes with overflow=1.
- Frame 8'h3C with stop bit driven 0 for 3·DIV → one frame_err pulse, FIFO unchanged, no new reception until rx returns high; then 8'h55 is received correctly.
- rx low pulse of 3 clocks → no byte, no frame_err, FSM back in IDLE.
- Fill to full=1, then assert rd on the same cycle a fifth byte's stop is sampled → byte stored, overflow stays 0, full stays 1. Assert rst=0 mid-frame → empty=1, full=0, overflow=0, data_out=8'h00.
